snn_img_loader: RTL and testbench
=================================

// Module: snn_img_loader
// PURPOSE
//  Unpacks UART bytes into the 1-bit-wide digit input RAM of the SNN core. It sits between
//  uart_rx and the input-image RAM. Each image is NUM_BITS pixels sent LSB-first, 8 pixels
//  per byte (784 px = 98 bytes). After the last pixel is written it raises img_rdy to the
//  core and holds it until img_ack. It then accepts the next image at address 0.
// PARAMETERS
//  NUM_BITS    784  pixels per image; must be a multiple of 8
//  ADDR_WIDTH  10   RAM address width; 2**ADDR_WIDTH >= NUM_BITS
// PORTS
//  clk        in   1           system clock
//  rst        in   1           synchronous, active-high reset
//  rx_rdy     in   1           uart_rx byte-valid; may be a pulse or a level
//  rx_data    in   8           uart_rx byte; valid while rx_rdy is high
//  img_ack    in   1           core has consumed the image; sampled only in DONE
//  ram_we     out  1           input-RAM write enable
//  ram_addr   out  ADDR_WIDTH  input-RAM write address
//  ram_wdata  out  1           input-RAM write data (one pixel)
//  img_rdy    out  1           full image is in RAM; high for the whole DONE state
//  busy       out  1           high in UNPACK or DONE
//  overrun    out  1           sticky: a byte was dropped; cleared by rst or img_ack
// BEHAVIOUR
//  Reset (rst high at a clk edge):
//   - state=IDLE; all outputs 0; pixel counter 0; byte register 0; rx_rdy_q=0.
//   - Reset wins over every other event in any state. A partial image is discarded.
//  Byte accept:
//   - A byte is accepted on a rising edge of rx_rdy: rx_rdy=1 and rx_rdy_q=0.
//   - rx_rdy_q is rx_rdy registered every cycle. This makes level and pulse sources equivalent.
//  IDLE:
//   - On accept, latch rx_data into byte_r and go to UNPACK with bit index k=0.
//  UNPACK (exactly 8 cycles per byte):
//   - Each cycle: ram_we=1, ram_addr=pix_cnt, ram_wdata=byte_r[k]; then pix_cnt+=1 and k+=1.
//   - Registered outputs: if rx_rdy is accepted at edge N, writes appear in cycles N+1..N+8.
//   - After k=7: if pix_cnt (post-increment) == NUM_BITS, go to DONE and set pix_cnt=0.
//     Otherwise return to IDLE.
//   - A byte accepted during UNPACK is dropped and sets overrun. The current byte completes normally.
//  DONE:
//   - img_rdy=1, ram_we=0.
//   - img_ack=1 -> IDLE: img_rdy=0 next cycle, overrun=0. A byte arriving that same cycle is dropped.
//   - A byte accepted while in DONE is dropped and sets overrun. RAM is never written in DONE.
//  Outputs:
//   - ram_we is 0 outside UNPACK; ram_addr/ram_wdata hold their last value when ram_we=0.
//   - busy = (state != IDLE).
//   - ram_addr never exceeds NUM_BITS-1; pix_cnt wraps to 0 only via the DONE transition.
//  img_ack outside DONE is ignored and does not clear overrun.
// TESTING
//  1. Reset, then byte 0xA5 -> 8 writes at addr 0..7, wdata 1,0,1,0,0,1,0,1 in consecutive
//     cycles starting 1 cycle after the rx_rdy edge; state returns to IDLE, img_rdy=0.
//  2. Send 98 bytes from a 784-bit image file -> the RAM model matches the file bit-for-bit.
//     img_rdy rises 1 cycle after the write to addr 783. No write ever exceeds addr 783.
//  3. rx_rdy held high for 20 cycles with 0xFF -> exactly one byte (8 writes) accepted.
//  4. Second rx_rdy edge 3 cycles into UNPACK -> overrun=1; addrs 0..7 carry the first byte only;
//     the next byte lands at addr 8.
//  5. In DONE, send byte 0x3C -> no ram_we, overrun=1. Pulse img_ack -> img_rdy=0, overrun=0.
//     The next byte writes addr 0..7.
//  6. Assert rst after 50 bytes and hold 1 cycle, mid-UNPACK -> all outputs 0 next cycle.
//     A fresh 98-byte image then loads from addr 0 and raises img_rdy.

Source files
------------

// File: rtl/snn_img_loader.sv
// snn_img_loader
//   Unpacks bytes from uart_rx into the 1-bit-wide input-image RAM of the SNN core.
//   Each image is NUM_BITS pixels. They arrive LSB-first, 8 pixels per byte. After
//   the last pixel is written, img_rdy is raised and held until the core acknowledges
//   with img_ack. The next image then starts again at address 0.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_rdy     uart_rx byte valid (pulse or level; only its rising edge counts)
//   rx_data    uart_rx byte, valid while rx_rdy is high
//   img_ack    core has consumed the image (only looked at while an image is ready)
//   ram_we     input-RAM write enable
//   ram_addr   input-RAM write address
//   ram_wdata  input-RAM write data (one pixel)
//   img_rdy    a full image is in RAM
//   busy       unpacking a byte or holding a finished image
//   overrun    sticky: a byte was dropped; cleared by rst or img_ack
module snn_img_loader #(
    parameter int unsigned NUM_BITS   = 784,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    input  logic                  img_ack,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wdata,
    output logic                  img_rdy,
    output logic                  busy,
    output logic                  overrun
);

    // One extra counter bit so the post-increment value NUM_BITS is representable
    // even when NUM_BITS == 2**ADDR_WIDTH.
    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] NumBitsC = CntW'(NUM_BITS);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StUnpack,
        StDone
    } state_e;

    state_e          state_q;
    logic            rx_rdy_q;
    logic [7:0]      byte_q;
    logic [2:0]      bit_q;    // index of the pixel currently driven on ram_wdata
    logic [CntW-1:0] pix_q;    // address of the next pixel to be written
    logic            accept;
    logic [2:0]      nxt_bit;

    // Edge detect makes level and pulse sources behave identically.
    assign accept  = rx_rdy & ~rx_rdy_q;
    assign nxt_bit = bit_q + 3'd1;

    // All outputs are registered: the write for pixel k is set up at the edge that
    // enters (or stays in) UNPACK, so a byte accepted at edge N is written during the
    // eight cycles that follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rx_rdy_q  <= 1'b0;
            byte_q    <= 8'h00;
            bit_q     <= 3'd0;
            pix_q     <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 1'b0;
            img_rdy   <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_rdy_q <= rx_rdy;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        // Pixel 0 comes straight from the bus; the rest from byte_q.
                        byte_q    <= rx_data;
                        bit_q     <= 3'd0;
                        ram_we    <= 1'b1;
                        ram_addr  <= pix_q[ADDR_WIDTH-1:0];
                        ram_wdata <= rx_data[0];
                        pix_q     <= pix_q + CntOne;
                        busy      <= 1'b1;
                        state_q   <= StUnpack;
                    end
                end
                StUnpack: begin
                    if (accept) begin
                        overrun <= 1'b1;
                    end
                    if (bit_q != 3'd7) begin
                        bit_q     <= nxt_bit;
                        ram_addr  <= pix_q[ADDR_WIDTH-1:0];
                        ram_wdata <= byte_q[nxt_bit];
                        pix_q     <= pix_q + CntOne;
                    end else begin
                        // Last pixel of this byte was driven in the cycle just ending.
                        ram_we <= 1'b0;
                        if (pix_q == NumBitsC) begin
                            pix_q   <= '0;
                            img_rdy <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                StDone: begin
                    // The acknowledge wins; a byte arriving with it is dropped silently.
                    if (img_ack) begin
                        img_rdy <= 1'b0;
                        overrun <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (accept) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Self-checking bench for snn_img_loader. The reference model treats each accepted byte
// as eight queued pixel writes that drain one per cycle, and tracks image-ready and
// overrun as plain flags.
module tb_snn_img_loader;

    localparam int NB = 784;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          img_ack;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_wdata;
    logic          img_rdy;
    logic          busy;
    logic          overrun;

    snn_img_loader #(
        .NUM_BITS   (NB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .img_ack   (img_ack),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .img_rdy   (img_rdy),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Reference model state
    bit m_prev_rdy;
    bit m_cur_we;
    bit m_done;
    bit m_ovr;
    int m_pix;
    int m_addr;
    bit m_wdata;
    int m_q[$];

    // RAM as seen by the bench
    bit ram_mem [0:1023];
    int n_writes = 0;
    int max_addr = 0;
    logic [7:0] img [0:97];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic present_next();
        int e;
        e        = m_q.pop_front();
        m_cur_we = 1'b1;
        m_addr   = e >> 1;
        m_wdata  = e[0];
    endtask

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_step();
        bit acc;
        if (rst) begin
            m_prev_rdy = 1'b0;
            m_cur_we   = 1'b0;
            m_done     = 1'b0;
            m_ovr      = 1'b0;
            m_pix      = 0;
            m_addr     = 0;
            m_wdata    = 1'b0;
            m_q.delete();
        end else begin
            acc        = rx_rdy && !m_prev_rdy;
            m_prev_rdy = rx_rdy;
            if (m_done) begin
                if (img_ack) begin
                    m_done = 1'b0;
                    m_ovr  = 1'b0;
                end else if (acc) begin
                    m_ovr = 1'b1;
                end
            end else if (m_cur_we) begin
                if (acc) m_ovr = 1'b1;
                if (m_q.size() > 0) begin
                    present_next();
                end else begin
                    m_cur_we = 1'b0;
                    if (m_pix == NB) begin
                        m_done = 1'b1;
                        m_pix  = 0;
                    end
                end
            end else if (acc) begin
                for (int i = 0; i < 8; i++) m_q.push_back(((m_pix + i) << 1) | int'(rx_data[i]));
                m_pix += 8;
                present_next();
            end
        end
    endtask

    // One clock: edge, then compare every output against the model away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        model_step();
        check("ram_we", 32'(ram_we), 32'(m_cur_we));
        check("ram_addr", 32'(ram_addr), 32'(m_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        check("img_rdy", 32'(img_rdy), 32'(m_done));
        check("busy", 32'(busy), 32'(m_cur_we || m_done));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (ram_we === 1'b1) begin
            check("addr_bound", 32'(int'(ram_addr) < NB), 32'd1);
            ram_mem[ram_addr] = ram_wdata;
            n_writes++;
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_data = b;
        rx_rdy  = 1'b1;
        repeat (hold) tick();
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] mem_byte(input int idx);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = ram_mem[idx * 8 + j];
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(ram_we), 32'd0);
        check({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_rdy"}, 32'(img_rdy), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    // Loads a random image with non-overlapping bytes of random length, then verifies it.
    task automatic load_image();
        int hold;
        int gap;
        max_addr = 0;
        for (int i = 0; i < 98; i++) begin
            img[i] = 8'($urandom);
            hold   = int'($urandom_range(1, 12));
            gap    = ((hold >= 9) ? 1 : 9 - hold) + int'($urandom_range(0, 3));
            send_byte(img[i], hold, gap);
        end
        for (int i = 0; i < 20 && img_rdy !== 1'b1; i++) tick();
        check("img_rdy_after_load", 32'(img_rdy), 32'd1);
        check("max_addr", 32'(max_addr), 32'(NB - 1));
        for (int i = 0; i < 98; i++) check("img_byte", 32'(mem_byte(i)), 32'(img[i]));
    endtask

    initial begin
        int w0;
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        img_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Single byte
        w0 = n_writes;
        send_byte(8'hA5, 1, 10);
        check("t1_writes", 32'(n_writes - w0), 32'd8);
        check("t1_byte", 32'(mem_byte(0)), 32'hA5);
        check("t1_rdy", 32'(img_rdy), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // Full image, then acknowledge
        do_reset();
        load_image();
        img_ack = 1'b1;
        tick();
        img_ack = 1'b0;
        check("t2_ack_rdy", 32'(img_rdy), 32'd0);

        // Level source: only one byte accepted
        w0 = n_writes;
        send_byte(8'hFF, 20, 5);
        check("t3_writes", 32'(n_writes - w0), 32'd8);
        check("t3_byte", 32'(mem_byte(0)), 32'hFF);

        // Second edge mid-unpack is dropped
        do_reset();
        send_byte(8'h11, 1, 2);
        send_byte(8'h22, 1, 10);
        check("t4_ovr", 32'(overrun), 32'd1);
        send_byte(8'h33, 1, 10);
        check("t4_byte0", 32'(mem_byte(0)), 32'h11);
        check("t4_byte1", 32'(mem_byte(1)), 32'h33);
        check("t4_ovr_sticky", 32'(overrun), 32'd1);

        // Byte while an image is ready
        do_reset();
        load_image();
        w0 = n_writes;
        send_byte(8'h3C, 1, 3);
        check("t5_no_write", 32'(n_writes - w0), 32'd0);
        check("t5_ovr", 32'(overrun), 32'd1);
        img_ack = 1'b1;
        tick();
        img_ack = 1'b0;
        check("t5_rdy", 32'(img_rdy), 32'd0);
        check("t5_ovr_clr", 32'(overrun), 32'd0);
        send_byte(8'hC3, 1, 10);
        check("t5_byte0", 32'(mem_byte(0)), 32'hC3);

        // Reset mid-image, mid-byte
        do_reset();
        for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1, 9);
        send_byte(8'h5A, 1, 3);
        do_reset();
        check_all_zero("t6_rst");
        load_image();
        img_ack = 1'b1;
        tick();
        img_ack = 1'b0;

        // Random traffic, acknowledges and rare resets against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rx_rdy  = ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom);
            img_ack = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst     = 1'b0;
        rx_rdy  = 1'b0;
        img_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
